// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared FSM state type and default constants for debounce_sync
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_CNT_W           = 16;
    localparam int DEF_GLITCH_W        = 8;

    function automatic state_t idle_state(input logic level);
        return level ? IDLE_HI : IDLE_LO;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-stage flip-flop synchroniser for a single asynchronous bit
module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= {STAGES{RESET_VAL}};
        end else begin
            stages <= {stages[STAGES-2:0], d};
        end
    end

    assign q = stages[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchroniser + debounce FSM + edge pulses; DEBOUNCE_GLITCH_CNT_EN adds glitch_cnt
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int   CNT_W           = DEF_CNT_W,
    parameter logic RESET_VAL       = 1'b0,
    parameter int   GLITCH_W        = DEF_GLITCH_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din_raw,
    output logic                d_clean,
    output logic                rise,
    output logic                fall,
    output logic                busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q;
    logic             abort;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din_raw),
        .q   (sync_q)
    );

    // A WAIT that sees the old level again is a rejected transition
    assign abort = ((state == WAIT_HI) && !sync_q) || ((state == WAIT_LO) && sync_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= idle_state(RESET_VAL);
            cnt     <= '0;
            d_clean <= RESET_VAL;
            rise    <= 1'b0;
            fall    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                IDLE_LO: if (sync_q) begin
                    state <= WAIT_HI;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
                IDLE_HI: if (!sync_q) begin
                    state <= WAIT_LO;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
                WAIT_HI: if (abort) begin
                    state <= IDLE_LO;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state   <= IDLE_HI;
                    cnt     <= '0;
                    busy    <= 1'b0;
                    d_clean <= 1'b1;
                    rise    <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                WAIT_LO: if (abort) begin
                    state <= IDLE_HI;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state   <= IDLE_LO;
                    cnt     <= '0;
                    busy    <= 1'b0;
                    d_clean <= 1'b0;
                    fall    <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    state <= idle_state(RESET_VAL);
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_cnt <= '0;
        end else if (abort && (glitch_cnt != {GLITCH_W{1'b1}})) begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - scoreboard bench for debounce_sync against a streak-count reference model
module tb_debounce_sync;

    localparam int S  = 2;
    localparam int D  = 4;
    localparam int GW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din_raw = 1'b1;
    logic d_clean, rise, fall, busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [GW-1:0] glitch_cnt;
`endif

    debounce_sync #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3),
        .RESET_VAL       (1'b0),
        .GLITCH_W        (GW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din_raw (din_raw),
        .d_clean (d_clean),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          d;
        logic          r;
        logic          f;
        logic          b;
        logic [GW-1:0] g;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 0;
    int   cycle    = 0;

    // Reference: sampled level is the raw input S edges ago; a new level is
    // accepted once it has disagreed with the current level for D+1 edges in a row.
    bit hist[$];
    bit level;
    int run;
    int glitch;

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < S; i++) hist.push_back(1'b0);
        level  = 1'b0;
        run    = 0;
        glitch = 0;
    endtask

    task automatic step(input bit r_rst, input bit r_raw);
        exp_t e;
        bit   s;
        @(negedge clk);
        rst     = r_rst;
        din_raw = r_raw;
        e.r = 1'b0;
        e.f = 1'b0;
        if (r_rst) begin
            model_reset();
        end else begin
            s = hist.pop_front();
            hist.push_back(r_raw);
            if (s != level) begin
                run++;
                if (run == D + 1) begin
                    level = s;
                    e.r   = s;
                    e.f   = !s;
                    run   = 0;
                end
            end else begin
                if (run > 0 && glitch < (1 << GW) - 1) glitch++;
                run = 0;
            end
        end
        e.d = level;
        e.b = (run > 0);
        e.g = GW'(glitch);
        exp_q.push_back(e);
    endtask

    task automatic hold(input bit v, input int n);
        repeat (n) step(1'b0, v);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cycle, act, req);
        end
    endtask

    task automatic driver();
        model_reset();
        repeat (3) step(1'b1, 1'b1);
        hold(1'b0, 8);
        hold(1'b1, 12);
        hold(1'b0, 12);
        step(1'b0, 1'b1);
        hold(1'b0, 8);
        hold(1'b1, 4);
        step(1'b1, 1'b1);
        hold(1'b0, 8);
        repeat (60) begin
            if ($urandom_range(0, 19) == 0) step(1'b1, 1'($urandom_range(0, 1)));
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
        end
        repeat (200) step(1'b0, 1'($urandom_range(0, 1)));
        step(1'b1, 1'b0);
        hold(1'b0, 4);
        repeat (300) begin
            step(1'b0, 1'b1);
            hold(1'b0, 3);
        end
        hold(1'b0, 5);
        @(negedge clk);
        done = 1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cycle++;
                check("d_clean", int'(d_clean), int'(e.d));
                check("rise", int'(rise), int'(e.r));
                check("fall", int'(fall), int'(e.f));
                check("busy", int'(busy), int'(e.b));
                check("rise_fall_exclusive", int'(rise && fall), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
                check("glitch_cnt", int'(glitch_cnt), int'(e.g));
`endif
            end else if (done) begin
                break;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=completion", cycle);
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            driver();
            monitor();
        join
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("glitch_saturated", int'(glitch_cnt), (1 << GW) - 1);
`endif
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
